// File: rtl/data_memory_pkg.sv
// ----------------------------------------------------------------------------
// data_memory_pkg : shared state encoding and port indices for the arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package data_memory_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_DATA = 1'b1
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

`default_nettype wire

// File: rtl/data_memory_arbiter.sv
// ----------------------------------------------------------------------------
// data_memory_arbiter : pipeline/DMA arbiter for a single-port data memory
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module data_memory_arbiter
  import data_memory_pkg::*;
#(
  parameter int dataSize       = 32,
  parameter int addressingSize = 32,
  parameter int vecSize        = 4,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,

  input  logic                                p0_req,
  input  logic                                p0_we,
  input  logic [addressingSize-1:0]           p0_addr,
  input  logic [vecSize-1:0][dataSize-1:0]    p0_wdata,
  output logic                                p0_gnt,
  output logic                                p0_rvalid,
  output logic [vecSize-1:0][dataSize-1:0]    p0_rdata,

  input  logic                                p1_req,
  input  logic                                p1_we,
  input  logic [addressingSize-1:0]           p1_addr,
  input  logic [vecSize-1:0][dataSize-1:0]    p1_wdata,
  output logic                                p1_gnt,
  output logic                                p1_rvalid,
  output logic [vecSize-1:0][dataSize-1:0]    p1_rdata,

  output logic                                mem_write_enable,
  output logic [addressingSize-1:0]           mem_DataAdr,
  output logic [vecSize-1:0][dataSize-1:0]    mem_toWrite_data,
  input  logic [vecSize-1:0][dataSize-1:0]    mem_read_data,

  output logic                                busy
);

  localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               starve_cnt_q, starve_cnt_d;
  logic                           owner_q, owner_d;
  logic [addressingSize-1:0]      addr_q, addr_d;
  logic [vecSize-1:0][dataSize-1:0] rdata0_q, rdata0_d;
  logic [vecSize-1:0][dataSize-1:0] rdata1_q, rdata1_d;

  logic                           any_req;
  logic                           starve_hit;
  logic                           p1_wins;
  logic                           win_idx;
  logic                           win_we;
  logic [addressingSize-1:0]      win_addr;
  logic [vecSize-1:0][dataSize-1:0] win_wdata;

  // Winner selection: port 0 by default, port 1 once it has lost STARVE_LIMIT times in a row.
  always_comb begin
    any_req    = p0_req | p1_req;
    starve_hit = (starve_cnt_q == STARVE_MAX);
    p1_wins    = p1_req & (~p0_req | starve_hit);
    win_idx    = p1_wins ? PORT_DMA : PORT_CPU;
    win_we     = p1_wins ? p1_we    : p0_we;
    win_addr   = p1_wins ? p1_addr  : p0_addr;
    win_wdata  = p1_wins ? p1_wdata : p0_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      owner_q      <= PORT_CPU;
      addr_q       <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    starve_cnt_d = starve_cnt_q;
    rdata0_d     = p0_rvalid ? mem_read_data : rdata0_q;
    rdata1_d     = p1_rvalid ? mem_read_data : rdata1_q;
    case (state_q)
      IDLE: begin
        // Writes complete at the closing edge; only reads need the data phase.
        if (any_req && !win_we) begin
          state_d = RD_DATA;
          owner_d = win_idx;
          addr_d  = win_addr;
        end
        if (!p1_req || p1_wins) begin
          starve_cnt_d = '0;
        end else if (!starve_hit) begin
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
      end
      RD_DATA: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grants and write enable are also gated by rst_n so nothing leaks while reset is held.
  always_comb begin
    p0_gnt           = 1'b0;
    p1_gnt           = 1'b0;
    p0_rvalid        = 1'b0;
    p1_rvalid        = 1'b0;
    mem_write_enable = 1'b0;
    mem_DataAdr      = p0_addr;
    mem_toWrite_data = p0_wdata;
    busy             = 1'b0;
    case (state_q)
      IDLE: begin
        mem_DataAdr      = win_addr;
        mem_toWrite_data = win_wdata;
        if (rst_n) begin
          p0_gnt           = p0_req & ~p1_wins;
          p1_gnt           = p1_wins;
          mem_write_enable = any_req & win_we;
        end
      end
      RD_DATA: begin
        busy        = 1'b1;
        mem_DataAdr = addr_q;
        p0_rvalid   = (owner_q == PORT_CPU);
        p1_rvalid   = (owner_q == PORT_DMA);
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    p0_rdata = p0_rvalid ? mem_read_data : rdata0_q;
    p1_rdata = p1_rvalid ? mem_read_data : rdata1_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
// ----------------------------------------------------------------------------
// tb_data_memory_arbiter : directed self-checking bench for data_memory_arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_data_memory_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int VS = 4;
  typedef logic [VS-1:0][DW-1:0] vec_t;

  localparam vec_t E10  = {32'hA000_0103, 32'hA000_0102, 32'hA000_0101, 32'hA000_0100};
  localparam vec_t DEAD = {4{32'hDEAD_BEEF}};
  localparam vec_t WP0  = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic p0_req = 1'b0, p1_req = 1'b0, p0_we = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  vec_t p0_wdata = '0, p1_wdata = '0;
  logic p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_write_enable, busy;
  vec_t p0_rdata, p1_rdata, mem_toWrite_data, mem_read_data;
  logic [AW-1:0] mem_DataAdr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_arbiter #(
    .dataSize(DW), .addressingSize(AW), .vecSize(VS), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_write_enable(mem_write_enable), .mem_DataAdr(mem_DataAdr),
    .mem_toWrite_data(mem_toWrite_data), .mem_read_data(mem_read_data),
    .busy(busy)
  );

  // Registered memory: 16-byte vectors, preloaded with A000_<idx><lane> while reset is held.
  vec_t mem [0:63];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++)
        for (int l = 0; l < VS; l++)
          mem[i][l] <= 32'hA000_0000 | (i << 8) | l;
    end else if (mem_write_enable) begin
      mem[mem_DataAdr[9:4]] <= mem_toWrite_data;
    end
    mem_read_data <= mem[mem_DataAdr[9:4]];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task test_reset;
    rst_n = 1'b0; p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b exp 00", {p0_gnt, p1_gnt}); end
    checks++; if ({p0_rvalid, p1_rvalid, busy, mem_write_enable} !== 4'b0000) begin errors++; $display("FAIL reset_ctl: got %b exp 0000", {p0_rvalid, p1_rvalid, busy, mem_write_enable}); end
    checks++; if ({p0_rdata, p1_rdata} !== '0) begin errors++; $display("FAIL reset_rdata: got %h %h exp 0", p0_rdata, p1_rdata); end
    p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0;
    rst_n = 1'b1;
  endtask

  task test_single_read;
    @(negedge clk); p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10; #1;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin errors++; $display("FAIL rd_gnt: got %b exp 10", {p0_gnt, p1_gnt}); end
    checks++; if (mem_DataAdr !== 32'h10 || mem_write_enable !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd_mem: got adr %h we %b busy %b exp 10 0 0", mem_DataAdr, mem_write_enable, busy); end
    @(negedge clk); p0_req = 1'b0; p0_addr = 32'h30; #1;
    checks++; if ({busy, p0_rvalid, p0_gnt} !== 3'b110) begin errors++; $display("FAIL rd_data_ctl: got %b exp 110", {busy, p0_rvalid, p0_gnt}); end
    checks++; if (p0_rdata !== E10) begin errors++; $display("FAIL rd_data: got %h exp %h", p0_rdata, E10); end
    checks++; if (mem_DataAdr !== 32'h10) begin errors++; $display("FAIL rd_hold_adr: got %h exp 10", mem_DataAdr); end
    @(negedge clk); #1;
    checks++; if ({busy, p0_rvalid} !== 2'b00) begin errors++; $display("FAIL rd_back_idle: got %b exp 00", {busy, p0_rvalid}); end
    checks++; if (p0_rdata !== E10) begin errors++; $display("FAIL rd_rdata_hold: got %h exp %h", p0_rdata, E10); end
    checks++; if (mem_DataAdr !== 32'h30 || mem_write_enable !== 1'b0) begin errors++; $display("FAIL idle_default: got adr %h we %b exp 30 0", mem_DataAdr, mem_write_enable); end
  endtask

  task test_write_readback;
    @(negedge clk); p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = DEAD; #1;
    checks++; if ({p0_gnt, p1_gnt, mem_write_enable} !== 3'b011) begin errors++; $display("FAIL wr_gnt: got %b exp 011", {p0_gnt, p1_gnt, mem_write_enable}); end
    checks++; if (mem_DataAdr !== 32'h20 || mem_toWrite_data !== DEAD) begin errors++; $display("FAIL wr_mem: got %h %h exp 20 %h", mem_DataAdr, mem_toWrite_data, DEAD); end
    @(negedge clk); p1_we = 1'b0; #1;
    checks++; if ({busy, p1_gnt, mem_write_enable} !== 3'b010) begin errors++; $display("FAIL wr_then_rd: got %b exp 010", {busy, p1_gnt, mem_write_enable}); end
    @(negedge clk); p1_req = 1'b0; #1;
    checks++; if ({p0_rvalid, p1_rvalid} !== 2'b01) begin errors++; $display("FAIL rb_rvalid: got %b exp 01", {p0_rvalid, p1_rvalid}); end
    checks++; if (p1_rdata !== DEAD) begin errors++; $display("FAIL rb_data: got %h exp %h", p1_rdata, DEAD); end
    checks++; if (p0_rdata !== E10) begin errors++; $display("FAIL rb_p0_hold: got %h exp %h", p0_rdata, E10); end
    @(negedge clk); #1;
    checks++; if ({busy, p1_rvalid} !== 2'b00) begin errors++; $display("FAIL rb_idle: got %b exp 00", {busy, p1_rvalid}); end
  endtask

  task test_contention;
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h40; p0_wdata = WP0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h20;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        #1;
        checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin errors++; $display("FAIL cont_p0_win r%0d c%0d: got %b exp 10", r, c, {p0_gnt, p1_gnt}); end
        @(negedge clk);
      end
      #1;
      checks++; if ({p0_gnt, p1_gnt} !== 2'b01) begin errors++; $display("FAIL cont_p1_forced r%0d: got %b exp 01", r, {p0_gnt, p1_gnt}); end
      @(negedge clk);
      if (r == 1) begin p0_req = 1'b0; p1_req = 1'b0; end
      #1;
      checks++; if ({p0_gnt, p1_gnt, busy, p1_rvalid} !== 4'b0011) begin errors++; $display("FAIL cont_rd r%0d: got %b exp 0011", r, {p0_gnt, p1_gnt, busy, p1_rvalid}); end
      checks++; if (p1_rdata !== DEAD) begin errors++; $display("FAIL cont_rdata r%0d: got %h exp %h", r, p1_rdata, DEAD); end
      @(negedge clk);
    end
  endtask

  task test_simultaneous_reads;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h20; #1;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin errors++; $display("FAIL sim_first: got %b exp 10", {p0_gnt, p1_gnt}); end
    @(negedge clk); p0_req = 1'b0; #1;
    checks++; if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid} !== 4'b0010) begin errors++; $display("FAIL sim_rd0: got %b exp 0010", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}); end
    checks++; if (p0_rdata !== E10) begin errors++; $display("FAIL sim_rdata0: got %h exp %h", p0_rdata, E10); end
    @(negedge clk); #1;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b01) begin errors++; $display("FAIL sim_second: got %b exp 01", {p0_gnt, p1_gnt}); end
    @(negedge clk); p1_req = 1'b0; #1;
    checks++; if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid} !== 4'b0001) begin errors++; $display("FAIL sim_rd1: got %b exp 0001", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}); end
    checks++; if (p1_rdata !== DEAD) begin errors++; $display("FAIL sim_rdata1: got %h exp %h", p1_rdata, DEAD); end
    @(negedge clk);
  endtask

  task test_reset_mid_read;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10; #1;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL rst_rd_gnt: got %b exp 1", p0_gnt); end
    @(negedge clk); p0_req = 1'b0; p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h50; rst_n = 1'b0; #1;
    checks++; if ({busy, p0_rvalid, p1_rvalid, p0_gnt, p1_gnt, mem_write_enable} !== 6'b0) begin errors++; $display("FAIL rst_mid_ctl: got %b exp 000000", {busy, p0_rvalid, p1_rvalid, p0_gnt, p1_gnt, mem_write_enable}); end
    checks++; if ({p0_rdata, p1_rdata} !== '0) begin errors++; $display("FAIL rst_mid_rdata: got %h %h exp 0", p0_rdata, p1_rdata); end
    @(negedge clk); #1;
    checks++; if ({busy, p0_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_held: got %b exp 00", {busy, p0_rvalid}); end
    rst_n = 1'b1; #1;
    checks++; if ({p0_gnt, p1_gnt, mem_write_enable} !== 3'b011) begin errors++; $display("FAIL rst_first_arb: got %b exp 011", {p0_gnt, p1_gnt, mem_write_enable}); end
    @(negedge clk); p1_req = 1'b0;
  endtask

  task test_requester_drop;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h40; p0_wdata = WP0;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h60; #1;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin errors++; $display("FAIL drop_pulse: got %b exp 10", {p0_gnt, p1_gnt}); end
    @(negedge clk); p1_req = 1'b0; #1;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin errors++; $display("FAIL drop_after: got %b exp 10", {p0_gnt, p1_gnt}); end
    @(negedge clk); p1_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin errors++; $display("FAIL drop_recount c%0d: got %b exp 10", c, {p0_gnt, p1_gnt}); end
      @(negedge clk);
    end
    #1;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b01) begin errors++; $display("FAIL drop_p1_forced: got %b exp 01", {p0_gnt, p1_gnt}); end
    @(negedge clk); p0_req = 1'b0; p1_req = 1'b0; #1;
    checks++; if ({p0_gnt, p1_gnt, busy, mem_write_enable} !== 4'b0000 || mem_DataAdr !== 32'h40) begin errors++; $display("FAIL drop_idle: got %b adr %h exp 0000 adr 40", {p0_gnt, p1_gnt, busy, mem_write_enable}, mem_DataAdr); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_readback();
    test_contention();
    test_simultaneous_reads();
    test_reset_mid_read();
    test_requester_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 SHALL have parameters: dataSize, 32, lane width in bits; addressingSize, 32, address width; vecSize, 4, lanes per access; STARVE_LIMIT, 4, consecutive port-1 losses before forced port-1 grant (1..15).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_req, p1_req  in  1  access request, port 0 = pipeline memory stage, port 1 = DMA/loader.
- p0_we, p1_we  in  1  1 = write, 0 = read.
- p0_addr, p1_addr  in  addressingSize  byte address.
- p0_wdata, p1_wdata  in  vecSize x dataSize  write vector.
- p0_gnt, p1_gnt  out  1  request accepted this cycle.
- p0_rvalid, p1_rvalid  out  1  read data valid.
- p0_rdata, p1_rdata  out  vecSize x dataSize  read vector.
- mem_write_enable  out  1  to the data memory write_enable.
- mem_DataAdr  out  addressingSize  to the data memory DataAdr.
- mem_toWrite_data  out  vecSize x dataSize  to the data memory toWrite_data.
- mem_read_data  in  vecSize x dataSize  from the data memory read_data, registered, valid one cycle after the read address is sampled.
- busy  out  1  high in RD_DATA.

Function
REQ-003 SHALL implement FSM states IDLE and RD_DATA.
REQ-004 In IDLE, SHALL select one winner among requesting ports: port 0, unless starve_cnt equals STARVE_LIMIT and p1_req is high, in which case port 1.
REQ-005 In IDLE, SHALL assert the winner's gnt combinationally in the same cycle, drive mem_DataAdr and mem_toWrite_data from the winner, and drive mem_write_enable equal to the winner's we.
REQ-006 SHALL accept a write in one cycle: memory is written at the closing clk edge, the FSM stays in IDLE, and a new grant is possible the next cycle.
REQ-007 On a granted read, SHALL transition to RD_DATA and register the winner's index and address.
REQ-008 In RD_DATA, SHALL:
- hold mem_DataAdr at the registered address;
- force mem_write_enable to 0;
- assert no gnt;
- pulse the owner's rvalid for exactly one cycle with rdata = mem_read_data;
- return to IDLE.
REQ-009 Read latency SHALL be exactly 1 cycle from gnt to rvalid; read throughput SHALL be 1 per 2 cycles.
REQ-010 rdata of a port SHALL hold its last delivered value when rvalid is low.
REQ-011 With no request in IDLE, SHALL drive mem_write_enable 0 and mem_DataAdr = p0_addr.
REQ-012 starve_cnt SHALL increment, saturating at STARVE_LIMIT, in each IDLE cycle where p1_req is high and port 0 is granted.
REQ-013 starve_cnt SHALL clear when port 1 is granted, or when p1_req is low in IDLE; it SHALL hold in RD_DATA.
REQ-014 Requesters SHALL hold req, we, addr and wdata stable until gnt; the arbiter SHALL NOT buffer ungranted requests.
REQ-015 When both ports request in the same cycle, exactly one gnt SHALL assert; two gnts SHALL never be high together.
REQ-016 A request dropped before gnt SHALL have no effect.

Reset
REQ-017 While rst_n is low, SHALL set: state IDLE, starve_cnt 0, all gnt 0, all rvalid 0, rdata 0, mem_write_enable 0, busy 0, registered index and address 0.
REQ-018 Reset asserted in RD_DATA SHALL abort the read with no rvalid pulse.
REQ-019 After rst_n rises, the first arbitration SHALL occur in the first IDLE cycle.

Structure
REQ-020 A shared package data_memory_pkg SHALL hold the state enum (IDLE, RD_DATA) and the port index constants PORT_CPU=0 and PORT_DMA=1.
REQ-021 starve_cnt width SHALL be $clog2(STARVE_LIMIT+1).
REQ-022 The block SHALL be a single module with no sub-module; starvation logic stays inline.

Verification
REQ-023 Single read: p0 read addr 0x10 -> p0_gnt cycle N, busy and p0_rvalid cycle N+1 with the memory vector at 0x10, back in IDLE at N+2.
REQ-024 Write then read-back: p1 write 0xDEADBEEF on all lanes at 0x20, then p1 read 0x20 -> p1_rdata all lanes 0xDEADBEEF one cycle after the read gnt.
REQ-025 Contention: p0 issues continuous writes, p1_req held high, STARVE_LIMIT=4 -> four p0 gnts, then p1_gnt on the 5th arbitration, starve_cnt back to 0.
REQ-026 Simultaneous reads: p0 and p1 read in the same cycle -> p0 served first, p1_gnt two cycles later, no cycle with both gnts high.
REQ-027 Reset mid-read: rst_n low during RD_DATA -> no rvalid, state IDLE, all outputs at reset values.
REQ-028 Requester drop: p1_req pulsed for one cycle while p0 is granted -> no p1_gnt, starve_cnt 0 afterward.
